seg_frame_reader: RTL and testbench
===================================

SEG_FRAME_READER -- requirements
Module: seg_frame_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, number of identical consecutive samples before a digit is accepted (legal 2..15).
REQ-002 SHALL have parameter NUM_DIGITS, fixed 4, number of multiplexed digit positions.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 seg  input  7  segment lines, active-low, seg[6]=a .. seg[0]=g.
REQ-006 an  input  4  digit enables, active-low, an[i] selects digit i (nibble i of out_data).
REQ-007 err_clr  input  1  synchronous clear of sticky flags.
REQ-008 out_data  output  16  captured frame, digit i in bits [4i+3:4i].
REQ-009 out_valid / out_ready  output / input  1 each  frame handshake; transfer when both high.
REQ-010 bad_code  output  1  sticky: a stable pattern matched no hex code.
REQ-011 overrun  output  1  sticky: a complete frame was dropped.

Function
REQ-012 Sampler FSM SHALL have states IDLE, SETTLE, LOCKED, re-evaluated every cycle.
REQ-013 IDLE: zero or more than one an bit low; counter cleared; no capture.
REQ-014 Exactly one an bit low SHALL move IDLE->SETTLE with counter=1; in SETTLE, {an,seg} equal to previous cycle increments counter, unequal reloads counter=1.
REQ-015 Counter reaching STABLE_CYCLES SHALL capture the pattern exactly once and move to LOCKED; LOCKED holds until {an,seg} changes (->SETTLE, counter=1) or anode count not one (->IDLE).
REQ-016 Capture SHALL decode seg: 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100 6=0100000 7=0001111 8=0000000 9=0000100 A=0001000 B=1100000 C=0110001 D=1000010 E=0110000 F=0111000.
REQ-017 Match SHALL write nibble to the digit slot of the active anode and set that slot's seen bit on the next edge; re-capture of a seen slot overwrites it.
REQ-018 No match SHALL set bad_code, leave the slot and seen bit unchanged.
REQ-019 When all four seen bits are set and out_valid is low (or out_ready is high that cycle), the next edge SHALL load out_data, assert out_valid, and clear all seen bits.
REQ-020 When all seen bits are set, out_valid high and out_ready low, the next edge SHALL set overrun, clear seen bits, and leave out_data/out_valid unchanged.
REQ-021 out_valid SHALL drop on the edge after a transfer unless REQ-019 reloads it the same edge; out_data SHALL be stable while out_valid is high and out_ready low.
REQ-022 err_clr SHALL clear bad_code and overrun; a same-cycle set SHALL win.
REQ-023 Latency: fourth digit captured at edge N -> seen set at N+1 -> out_valid high after N+2.

Reset
REQ-024 rst_n low SHALL immediately force FSM=IDLE, counter=0, seen=0, slots=0, out_data=0, out_valid=0, bad_code=0, overrun=0 (dp outputs 0 when compiled in).
REQ-025 Reset mid-frame SHALL discard partial digits; first frame after release requires all four digits again.

Configuration
REQ-026 Macro SEG_FRAME_READER_DP_EN: when defined, adds input dp (1, active-low) included in the stability compare and captured per digit, and output out_dp[3:0] loaded with out_data.
REQ-027 Without SEG_FRAME_READER_DP_EN, no dp port exists and stability compares only {an,seg}.

Structure
REQ-028 Package seg_reader_pkg SHALL hold the 16-entry code table, the sampler state enum, and NUM_DIGITS.
REQ-029 Sub-module seg_pattern_decode SHALL be the combinational 7-bit -> {hit, nibble} lookup; sampler, slots and handshake live in the top.

Verification
REQ-030 an=1110 seg=0000110 held 4 cycles, then digits 1..3 with 1001111/0010010/1001100, out_ready=1 -> out_data=16'h4213, out_valid one cycle.
REQ-031 an=1101 seg alternating every cycle for 10 cycles -> no capture, seen unchanged.
REQ-032 Stable seg=1111111 on an=1011 -> bad_code=1 and stays 1 until err_clr; slot 2 unchanged.
REQ-033 out_ready=0 after frame 16'hABCD, second full frame 16'h1234 -> overrun=1, out_data stays 16'hABCD.
REQ-034 rst_n pulsed low after 2 digits captured -> all outputs 0 asynchronously; 2 more digits produce no frame.
REQ-035 an=1100 held stable -> IDLE, no capture; with DP_EN, dp=0 on digit 0 frame -> out_dp=4'b0001.

Source files
------------

// File: rtl/seg_reader_pkg.sv
// seg_reader_pkg -- shared definitions for the seven-segment frame reader.
//
// Contents:
//   NUM_DIGITS       number of multiplexed digit positions (fixed at 4)
//   SEG_CODE_TABLE   active-low segment pattern for each hex nibble,
//                    bit 6 = segment a .. bit 0 = segment g
//   sampler_state_e  sampler FSM state encoding
//   exactly_one_low  true when exactly one anode line is driven low
//   low_index        position of the low anode line
//
// Optional feature macro used by the files that import this package:
//   SEG_FRAME_READER_DP_EN (decimal-point capture)
package seg_reader_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SEG_W      = 7;
  localparam int NIB_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2
  } sampler_state_e;

  // Entry i is the pattern that displays hex digit i.
  localparam logic [15:0][SEG_W-1:0] SEG_CODE_TABLE = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // D
    7'b0110001,  // C
    7'b1100000,  // B
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  function automatic logic exactly_one_low(input logic [NUM_DIGITS-1:0] an);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      n = n + {2'b00, ~an[i]};
    end
    return (n == 3'd1);
  endfunction

  function automatic logic [1:0] low_index(input logic [NUM_DIGITS-1:0] an);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_frame_reader_if.sv
// seg_frame_reader_if -- frame output handshake of the segment reader.
//
// Signals:
//   out_data   captured frame, digit i in bits [4i+3:4i]
//   out_valid  frame available
//   out_ready  consumer accepts; a transfer happens when both are high
//   out_dp     per-digit decimal point, lit = 1 (only with SEG_FRAME_READER_DP_EN)
//
// Modports: master = reader side, slave = consumer side.
interface seg_frame_reader_if;
  import seg_reader_pkg::*;

  logic [NIB_W*NUM_DIGITS-1:0] out_data;
  logic                        out_valid;
  logic                        out_ready;
`ifdef SEG_FRAME_READER_DP_EN
  logic [NUM_DIGITS-1:0]       out_dp;

  modport master (output out_data, output out_valid, output out_dp, input out_ready);
  modport slave  (input out_data, input out_valid, input out_dp, output out_ready);
`else
  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
`endif

endinterface

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode -- combinational lookup of a 7-bit active-low segment
// pattern against the hex code table.
//
// Ports:
//   pattern  in   7  segment pattern, bit 6 = a .. bit 0 = g
//   hit      out  1  pattern matched one of the 16 hex codes
//   nibble   out  4  matched hex value (0 when no hit)
module seg_pattern_decode
  import seg_reader_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  output logic             hit,
  output logic [NIB_W-1:0] nibble
);

  // Table entries are distinct, so at most one comparison succeeds.
  always_comb begin
    hit    = 1'b0;
    nibble = '0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == SEG_CODE_TABLE[i]) begin
        hit    = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg_frame_reader.sv
// seg_frame_reader -- samples a multiplexed seven-segment display bus,
// debounces each digit, decodes it to hex and presents complete 4-digit
// frames on a valid/ready handshake.
//
// Parameters:
//   STABLE_CYCLES  identical consecutive samples before a digit is accepted (2..15)
//   NUM_DIGITS     multiplexed digit positions (fixed at 4)
//
// Ports:
//   clk       in   1   clock, rising edge
//   rst_n     in   1   asynchronous active-low reset
//   seg       in   7   segment lines, active-low, seg[6]=a .. seg[0]=g
//   an        in   4   digit enables, active-low, an[i] selects digit i
//   dp        in   1   decimal point, active-low (SEG_FRAME_READER_DP_EN only)
//   err_clr   in   1   synchronous clear of the sticky flags
//   frm       master modport of seg_frame_reader_if (out_data/out_valid/out_ready[/out_dp])
//   bad_code  out  1   sticky: a stable pattern matched no hex code
//   overrun   out  1   sticky: a complete frame was dropped
//
// Optional feature: define SEG_FRAME_READER_DP_EN to add decimal-point capture.
//
// Pipeline: p0 = sampler + capture register, p1 = decode into digit slots,
// p2 = frame output register. A capture at edge N lands in its slot at N+1
// and a completed frame reaches out_valid at N+2.
module seg_frame_reader #(
  parameter int STABLE_CYCLES = 4,
  parameter int NUM_DIGITS    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg,
  input  logic [NUM_DIGITS-1:0] an,
`ifdef SEG_FRAME_READER_DP_EN
  input  logic                  dp,
`endif
  input  logic                  err_clr,
  seg_frame_reader_if.master    frm,
  output logic                  bad_code,
  output logic                  overrun
);
  import seg_reader_pkg::*;

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] SETTLE = ST_SETTLE;
  localparam logic [1:0] LOCKED = ST_LOCKED;

`ifdef SEG_FRAME_READER_DP_EN
  localparam int SMP_W = NUM_DIGITS + SEG_W + 1;
`else
  localparam int SMP_W = NUM_DIGITS + SEG_W;
`endif

  logic [SMP_W-1:0] smp;
`ifdef SEG_FRAME_READER_DP_EN
  assign smp = {an, seg, dp};
`else
  assign smp = {an, seg};
`endif

  logic one_low;
  assign one_low = exactly_one_low(an);

  // ---------------- p0: sampler FSM and capture register ----------------
  logic [1:0]       state_p0, state_nxt;
  logic [3:0]       cnt_p0, cnt_nxt;
  logic [SMP_W-1:0] smp_prev_p0;
  logic             capture;

  logic             cap_vld_p0;
  logic [SEG_W-1:0] cap_seg_p0;
  logic [1:0]       cap_idx_p0;
`ifdef SEG_FRAME_READER_DP_EN
  logic             cap_dp_p0;
`endif

  always_comb begin
    state_nxt = state_p0;
    cnt_nxt   = cnt_p0;
    capture   = 1'b0;
    if (!one_low) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state_p0)
        SETTLE: begin
          if (smp == smp_prev_p0) begin
            cnt_nxt = cnt_p0 + 4'd1;
            // Counter only climbs inside SETTLE, so the match fires once.
            if (cnt_nxt == 4'(STABLE_CYCLES)) begin
              capture   = 1'b1;
              state_nxt = LOCKED;
            end
          end else begin
            cnt_nxt = 4'd1;
          end
        end
        LOCKED: begin
          if (smp != smp_prev_p0) begin
            state_nxt = SETTLE;
            cnt_nxt   = 4'd1;
          end
        end
        default: begin
          state_nxt = SETTLE;
          cnt_nxt   = 4'd1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0    <= IDLE;
      cnt_p0      <= '0;
      smp_prev_p0 <= '0;
      cap_vld_p0  <= 1'b0;
      cap_seg_p0  <= '0;
      cap_idx_p0  <= '0;
`ifdef SEG_FRAME_READER_DP_EN
      cap_dp_p0   <= 1'b0;
`endif
    end else begin
      state_p0    <= state_nxt;
      cnt_p0      <= cnt_nxt;
      smp_prev_p0 <= smp;
      cap_vld_p0  <= capture;
      if (capture) begin
        cap_seg_p0 <= seg;
        cap_idx_p0 <= low_index(an);
`ifdef SEG_FRAME_READER_DP_EN
        cap_dp_p0  <= ~dp;
`endif
      end
    end
  end

  // ---------------- p1: decode into digit slots ----------------
  logic                             dec_hit;
  logic [NIB_W-1:0]                 dec_nib;
  logic [NUM_DIGITS-1:0][NIB_W-1:0] slot_p1;
  logic [NUM_DIGITS-1:0]            seen_p1, seen_set, seen_nxt;
`ifdef SEG_FRAME_READER_DP_EN
  logic [NUM_DIGITS-1:0]            slot_dp_p1;
`endif

  seg_pattern_decode u_decode (
    .pattern (cap_seg_p0),
    .hit     (dec_hit),
    .nibble  (dec_nib)
  );

  logic frame_full, frame_load, frame_drop, bad_set;
  logic out_valid_p2;

  assign frame_full = &seen_p1;
  assign frame_load = frame_full && (!out_valid_p2 || frm.out_ready);
  assign frame_drop = frame_full && out_valid_p2 && !frm.out_ready;
  assign bad_set    = cap_vld_p0 && !dec_hit;

  always_comb begin
    seen_set = '0;
    if (cap_vld_p0 && dec_hit) seen_set[cap_idx_p0] = 1'b1;
  end

  // A fresh capture survives the frame-complete clear of the seen bits.
  assign seen_nxt = (frame_full ? '0 : seen_p1) | seen_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_p1    <= '0;
      seen_p1    <= '0;
`ifdef SEG_FRAME_READER_DP_EN
      slot_dp_p1 <= '0;
`endif
    end else begin
      seen_p1 <= seen_nxt;
      if (cap_vld_p0 && dec_hit) begin
        slot_p1[cap_idx_p0]    <= dec_nib;
`ifdef SEG_FRAME_READER_DP_EN
        slot_dp_p1[cap_idx_p0] <= cap_dp_p0;
`endif
      end
    end
  end

  // ---------------- p2: frame output and sticky flags ----------------
  logic [NIB_W*NUM_DIGITS-1:0] out_data_p2;
  logic                        bad_code_p2, overrun_p2;
`ifdef SEG_FRAME_READER_DP_EN
  logic [NUM_DIGITS-1:0]       out_dp_p2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_p2  <= '0;
      out_valid_p2 <= 1'b0;
      bad_code_p2  <= 1'b0;
      overrun_p2   <= 1'b0;
`ifdef SEG_FRAME_READER_DP_EN
      out_dp_p2    <= '0;
`endif
    end else begin
      out_valid_p2 <= frame_load || (out_valid_p2 && !frm.out_ready);
      if (frame_load) begin
        out_data_p2 <= slot_p1;
`ifdef SEG_FRAME_READER_DP_EN
        out_dp_p2   <= slot_dp_p1;
`endif
      end
      bad_code_p2 <= bad_set    || (bad_code_p2 && !err_clr);
      overrun_p2  <= frame_drop || (overrun_p2  && !err_clr);
    end
  end

  assign frm.out_data  = out_data_p2;
  assign frm.out_valid = out_valid_p2;
`ifdef SEG_FRAME_READER_DP_EN
  assign frm.out_dp    = out_dp_p2;
`endif
  assign bad_code      = bad_code_p2;
  assign overrun       = overrun_p2;

endmodule

// File: tb/tb_seg_frame_reader.sv
// tb_seg_frame_reader -- directed scenarios plus randomized segment traffic
// checked every cycle against a behavioural model of the reader.
module tb_seg_frame_reader;

  localparam int STABLE = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg = 7'h7F;
  logic [3:0] an = 4'hF;
  logic       dp = 1'b1;
  logic       err_clr = 1'b0;
  logic       bad_code, overrun;

  seg_frame_reader_if frm();

  seg_frame_reader #(.STABLE_CYCLES(STABLE), .NUM_DIGITS(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .seg      (seg),
    .an       (an),
`ifdef SEG_FRAME_READER_DP_EN
    .dp       (dp),
`endif
    .err_clr  (err_clr),
    .frm      (frm),
    .bad_code (bad_code),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Hex display codes, index = displayed value.
  logic [6:0] code_tbl [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // ---------------- reference model ----------------
  typedef struct {
    int         due;
    logic [6:0] pat;
    int         idx;
  } cap_t;

  cap_t        pq[$];
  int          ecount = 0;
  int          run = 0;
  logic [10:0] m_prev = '0;
  logic [3:0]  m_slot [4];
  logic [3:0]  m_seen;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_bad, m_ovr;

  int          xfer_cnt = 0;
  logic [15:0] last_xfer = '0;
  int          vcnt = 0;
  bit          rand_mode = 0;

  task automatic model_reset();
    pq.delete();
    run = 0;
    for (int i = 0; i < 4; i++) m_slot[i] = '0;
    m_seen = '0; m_valid = 0; m_data = '0; m_bad = 0; m_ovr = 0;
  endtask

  function automatic int zeros(input logic [3:0] a);
    int n = 0;
    for (int i = 0; i < 4; i++) if (!a[i]) n++;
    return n;
  endfunction

  function automatic int zero_pos(input logic [3:0] a);
    int p = 0;
    for (int i = 0; i < 4; i++) if (!a[i]) p = i;
    return p;
  endfunction

  // Advance the model across one rising edge using the inputs present at it.
  task automatic model_edge();
    bit bad_set = 0, ovr_set = 0;
    logic [10:0] cur;
    ecount++;
    // A complete frame is presented one edge after its last slot fills.
    if (m_seen == 4'hF) begin
      if (!m_valid || frm.out_ready) begin
        m_valid = 1;
        m_data  = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
      end else begin
        ovr_set = 1;
      end
      m_seen = '0;
    end else if (m_valid && frm.out_ready) begin
      m_valid = 0;
    end
    // Accepted digits land in their slot one edge after acceptance.
    while (pq.size() > 0 && pq[0].due == ecount) begin
      cap_t c;
      bit hit = 0;
      c = pq.pop_front();
      for (int v = 0; v < 16; v++) begin
        if (code_tbl[v] == c.pat) begin
          hit = 1;
          m_slot[c.idx] = 4'(v);
        end
      end
      if (hit) m_seen[c.idx] = 1'b1;
      else bad_set = 1;
    end
    m_bad = bad_set || (m_bad && !err_clr);
    m_ovr = ovr_set || (m_ovr && !err_clr);
    // A digit is accepted when its run of identical samples reaches STABLE.
    cur = {an, seg};
    if (zeros(an) == 1) begin
      if (run > 0 && cur == m_prev) run++;
      else run = 1;
      if (run == STABLE) pq.push_back('{due: ecount + 1, pat: seg, idx: zero_pos(an)});
    end else begin
      run = 0;
    end
    m_prev = cur;
  endtask

  task automatic step();
    if (rand_mode) begin
      frm.out_ready = ($urandom_range(0, 9) < 7);
      err_clr       = ($urandom_range(0, 19) == 0);
    end
    if (frm.out_valid && frm.out_ready) begin
      xfer_cnt++;
      last_xfer = frm.out_data;
    end
    @(posedge clk);
    model_edge();
    #1;
    chk("out_valid", 32'(frm.out_valid), 32'(m_valid));
    chk("out_data", 32'(frm.out_data), 32'(m_data));
    chk("bad_code", 32'(bad_code), 32'(m_bad));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    if (frm.out_valid) vcnt++;
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    an = a; seg = s;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_frame(input logic [15:0] v);
    for (int d = 0; d < 4; d++) begin
      logic [3:0] a;
      a = 4'hF;
      a[d] = 1'b0;
      hold(a, code_tbl[v[4*d +: 4]], STABLE);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(frm.out_valid), 32'd0);
    chk({tag, "_data"}, 32'(frm.out_data), 32'd0);
    chk({tag, "_bad"}, 32'(bad_code), 32'd0);
    chk({tag, "_ovr"}, 32'(overrun), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int x0;
    frm.out_ready = 1'b1;
    model_reset();
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Frame 4213 with a ready consumer: one valid cycle.
    vcnt = 0;
    hold(4'b1110, 7'b0000110, 4);
    hold(4'b1101, 7'b1001111, 4);
    hold(4'b1011, 7'b0010010, 4);
    hold(4'b0111, 7'b1001100, 4);
    hold(4'b1111, 7'h7F, 6);
    chk("frame_4213", 32'(last_xfer), 32'h4213);
    chk("frame_4213_vcycles", 32'(vcnt), 32'd1);

    // Changing pattern never settles.
    x0 = xfer_cnt;
    for (int i = 0; i < 10; i++) hold(4'b1101, (i % 2) ? 7'b0000110 : 7'b0010010, 1);
    hold(4'b1100, 7'b0000001, 8);
    hold(4'b1111, 7'h7F, 4);
    chk("no_capture_bad", 32'(bad_code), 32'd0);

    // Unknown pattern sets a sticky flag until err_clr.
    hold(4'b1011, 7'b1111111, 5);
    hold(4'b1111, 7'h7F, 3);
    chk("bad_sticky", 32'(bad_code), 32'd1);
    err_clr = 1'b1; hold(4'b1111, 7'h7F, 1); err_clr = 1'b0;
    chk("bad_cleared", 32'(bad_code), 32'd0);

    // Stalled consumer: second frame dropped, first frame held.
    frm.out_ready = 1'b0;
    send_frame(16'hABCD);
    hold(4'b1111, 7'h7F, 3);
    send_frame(16'h1234);
    hold(4'b1111, 7'h7F, 3);
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_data_held", 32'(frm.out_data), 32'hABCD);
    chk("ovr_valid_held", 32'(frm.out_valid), 32'd1);
    frm.out_ready = 1'b1;
    hold(4'b1111, 7'h7F, 2);
    chk("ovr_xfer", 32'(last_xfer), 32'hABCD);
    err_clr = 1'b1; hold(4'b1111, 7'h7F, 1); err_clr = 1'b0;
    chk("ovr_cleared", 32'(overrun), 32'd0);

    // Reset mid-frame discards captured digits.
    hold(4'b1110, code_tbl[5], 4);
    hold(4'b1101, code_tbl[6], 4);
    hold(4'b1111, 7'h7F, 1);
    do_reset();
    x0 = xfer_cnt;
    hold(4'b1011, code_tbl[7], 4);
    hold(4'b0111, code_tbl[8], 4);
    hold(4'b1111, 7'h7F, 6);
    chk("rst_no_frame", 32'(xfer_cnt - x0), 32'd0);
    chk("rst_no_valid", 32'(frm.out_valid), 32'd0);

    // Randomized traffic.
    rand_mode = 1;
    for (int h = 0; h < 600; h++) begin
      logic [3:0] a;
      logic [6:0] s;
      if ($urandom_range(0, 99) < 85) begin
        a = 4'hF;
        a[$urandom_range(0, 3)] = 1'b0;
      end else begin
        a = 4'($urandom);
      end
      if ($urandom_range(0, 99) < 90) s = code_tbl[$urandom_range(0, 15)];
      else s = 7'($urandom);
      hold(a, s, $urandom_range(1, 6));
      if (h == 300) do_reset();
    end
    rand_mode = 0;
    err_clr = 1'b0;
    frm.out_ready = 1'b1;
    hold(4'b1111, 7'h7F, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
